// File: rtl/ones_zeros_pattern_gen_if.sv
// Request/serial-output bundle for ones_zeros_pattern_gen.
// The master drives requests. The slave, which is the generator, drives the serial word and its counts.
interface ones_zeros_pattern_gen_if #(
    parameter int unsigned CW = 4
);
    logic          req_valid;
    logic [CW-1:0] ones_req;
    logic          req_ready;
    logic          serial_out;
    logic          out_valid;
    logic          done;
    logic [CW-1:0] ones_cnt;
    logic [CW-1:0] zeros_cnt;
    logic [CW-1:0] diff;

    modport master (
        output req_valid,
        output ones_req,
        input  req_ready,
        input  serial_out,
        input  out_valid,
        input  done,
        input  ones_cnt,
        input  zeros_cnt,
        input  diff
    );

    modport slave (
        input  req_valid,
        input  ones_req,
        output req_ready,
        output serial_out,
        output out_valid,
        output done,
        output ones_cnt,
        output zeros_cnt,
        output diff
    );
endinterface

// File: rtl/ones_zeros_pattern_gen.sv
// Serial word generator. An N-bit word holds K ones in its LSBs and is shifted out MSB-first.
// The block counts the ones and zeros it emits and reports |ones - zeros| when the word finishes.
module ones_zeros_pattern_gen #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 4
) (
    input logic                      clk,
    input logic                      rst,
    ones_zeros_pattern_gen_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [CW-1:0] NCw   = CW'(N);
    localparam logic [CW-1:0] NLast = CW'(N - 1);
    localparam logic [CW:0]   NWide = (CW + 1)'(N);

    state_e        state_q, state_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] k_q, k_d;
    logic [CW-1:0] ones_q, ones_d;
    logic [CW-1:0] zeros_q, zeros_d;
    logic [CW-1:0] diff_q, diff_d;

    logic          accept;
    logic          last_bit;
    logic [CW-1:0] k_sat;
    logic [N-1:0]  load_word;
    logic [CW:0]   twice_k;
    logic [CW-1:0] final_diff;

    assign accept    = (state_q == StIdle) && bus.req_valid;
    assign last_bit  = (state_q == StShift) && (idx_q == NLast);
    assign k_sat     = (bus.ones_req > NCw) ? NCw : bus.ones_req;
    // Shifting all-ones left by K leaves K zeros at the bottom. Inverting gives K ones in the LSBs.
    assign load_word = ~({N{1'b1}} << k_sat);

    // |K - (N - K)| == |2K - N|. The larger value is chosen first, so the subtraction never underflows.
    assign twice_k    = {k_q, 1'b0};
    assign final_diff = (twice_k >= NWide) ? CW'(twice_k - NWide) : CW'(NWide - twice_k);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.req_valid) state_d = StShift;
            StShift: if (last_bit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        bus.req_ready  = (state_q == StIdle);
        bus.out_valid  = (state_q == StShift);
        bus.done       = (state_q == StDone);
        bus.serial_out = (state_q == StShift) && shreg_q[N-1];
        bus.ones_cnt   = ones_q;
        bus.zeros_cnt  = zeros_q;
        bus.diff       = diff_q;
    end

    // Datapath next-state
    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        k_d     = k_q;
        ones_d  = ones_q;
        zeros_d = zeros_q;
        diff_d  = diff_q;
        if (accept) begin
            k_d     = k_sat;
            shreg_d = load_word;
            idx_d   = '0;
            ones_d  = '0;
            zeros_d = '0;
            diff_d  = '0;
        end else if (state_q == StShift) begin
            shreg_d = shreg_q << 1;
            idx_d   = idx_q + 1'b1;
            if (shreg_q[N-1]) begin
                ones_d = ones_q + 1'b1;
            end else begin
                zeros_d = zeros_q + 1'b1;
            end
            if (last_bit) begin
                diff_d = final_diff;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            idx_q   <= '0;
            k_q     <= '0;
            ones_q  <= '0;
            zeros_q <= '0;
            diff_q  <= '0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            ones_q  <= ones_d;
            zeros_q <= zeros_d;
            diff_q  <= diff_d;
        end
    end

    // Every finished word has emitted exactly N bits in total.
    a_done_total: assert property (@(posedge clk) disable iff (rst)
        (state_q == StDone) |-> (CW'(ones_q + zeros_q) == NCw));

    a_idle_quiet: assert property (@(posedge clk) disable iff (rst)
        (state_q != StShift) |-> !bus.serial_out);

endmodule

// File: doc/ones_zeros_pattern_gen.md
ONES_ZEROS_PATTERN_GEN -- requirements
Module: ones_zeros_pattern_gen

Interface
REQ-001 Parameter N, default 8: word length in bits; supported range 2..15.
REQ-002 Parameter CW, default 4: width of every count and difference field; CW SHALL satisfy 2^CW > N.
REQ-003 clk  input  1: sole clock; all state updates on its rising edge.
REQ-004 rst  input  1: reset, asynchronous and active-high.
REQ-005 req_valid  input  1: request strobe; sampled only while req_ready=1.
REQ-006 ones_req  input  CW: requested number of ones in the generated word.
REQ-007 req_ready  output  1: high only in IDLE.
REQ-008 serial_out  output  1: current serial data bit.
REQ-009 out_valid  output  1: serial_out carries a valid word bit this cycle.
REQ-010 done  output  1: one-cycle pulse after the last bit of a word.
REQ-011 ones_cnt  output  CW: ones emitted so far in the current word.
REQ-012 zeros_cnt  output  CW: zeros emitted so far in the current word.
REQ-013 diff  output  CW: |ones_cnt - zeros_cnt|; valid and held while done=1.

Function
REQ-014 FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-015 IDLE -> SHIFT on the clock edge where req_valid=1; the request is then accepted. IDLE with req_valid=0 stays in IDLE.
REQ-016 On accept, K = min(ones_req, N) SHALL be latched, i.e. requests above N saturate to N.
REQ-017 On accept, an N-bit shift register SHALL be loaded with (N-K) zeros in the MSBs and K ones in the LSBs (for example N=8, K=7 gives 0111_1111).
REQ-018 On the same edge, the bit index SHALL be cleared to 0, and ones_cnt and zeros_cnt SHALL be cleared to 0.
REQ-019 In SHIFT, out_valid SHALL be 1 and serial_out SHALL present the word MSB-first, one bit per cycle, for exactly N consecutive cycles.
REQ-020 Latency: the first bit SHALL appear in the cycle immediately after the accept edge.
REQ-021 On each SHIFT edge, the counter for the emitted bit value SHALL increment by 1; counters SHALL never wrap because 2^CW > N.
REQ-022 After the edge that counts bit N-1, the FSM SHALL move SHIFT -> DONE.
REQ-023 In DONE, done=1 and out_valid=0 for exactly one cycle; ones_cnt=K, zeros_cnt=N-K, and diff=|K-(N-K)| computed without underflow.
REQ-024 DONE -> IDLE unconditionally; diff SHALL hold its value until the next accept.
REQ-025 req_valid and ones_req SHALL be ignored outside IDLE; changes during SHIFT SHALL not alter the word in flight.
REQ-026 Back-to-back requests: with req_valid held at 1, the next accept occurs in the first IDLE cycle after DONE, so the spacing is N+2 cycles per word.
REQ-027 K=0 SHALL produce N zeros; K=N SHALL produce N ones. Both cases end with diff=N.
REQ-028 serial_out SHALL be 0 whenever out_valid=0.

Reset
REQ-029 Asserting rst SHALL immediately set FSM=IDLE, req_ready=1, and out_valid=0, done=0, serial_out=0.
REQ-030 The same assertion SHALL clear ones_cnt, zeros_cnt, diff, the shift register and the bit index, all independent of clk.
REQ-031 Reset during SHIFT or DONE SHALL abort the word with no done pulse; operation resumes at the first accept after rst deasserts.

Verification
REQ-032 N=8, ones_req=7 -> serial 0,1,1,1,1,1,1,1 on cycles 1-8 after accept; done on cycle 9 with ones_cnt=7, zeros_cnt=1, diff=6.
REQ-033 ones_req=4 -> 0000_1111 MSB-first; done with diff=0.
REQ-034 Edge counts: ones_req=0 -> eight zeros, diff=8; ones_req=8 -> eight ones, diff=8; ones_req=12 -> saturates to eight ones, diff=8.
REQ-035 req_valid held high, ones_req 3 then 5 -> accepts exactly 10 cycles apart; diffs 2 then 2; ones_req changes mid-word have no effect.
REQ-036 rst pulsed asynchronously on the 4th SHIFT cycle -> outputs and counters zero immediately, no done pulse, req_ready=1; a fresh ones_req=1 then yields 0000_0001 and diff=6.
REQ-037 Scoreboard on every test: out_valid high for exactly N cycles per word, and done high for exactly 1 cycle per word.
